rot_enc_multi: RTL and testbench

Multi-channel quadrature rotary-encoder front end for the audio multi-effects processor's control panel. Each channel synchronises and debounces its A/B pins, decodes every valid quadrature transition, divides it down to detent steps, and keeps a signed position count that either saturates or wraps. Detent steps are also queued as direction events and handed to the effect-parameter controller through a round-robin valid/ready port. The block supersedes the single-channel left/right pulse decoder.

---
 rtl/rot_enc_pkg.sv | 39 +++
 rtl/rot_enc_ch.sv | 115 +++++++++++
 rtl/rot_enc_multi.sv | 87 ++++++++
 tb/tb_rot_enc_multi.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_enc_pkg.sv
// Shared encodings for the rotary-encoder front end: direction codes, the
// quadrature Gray sequence and the phase-delta decode helper.
package rot_enc_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // {B,A} positions of the clockwise Gray sequence
  localparam logic [1:0] QUAD_S0 = 2'b00;
  localparam logic [1:0] QUAD_S1 = 2'b01;
  localparam logic [1:0] QUAD_S2 = 2'b11;
  localparam logic [1:0] QUAD_S3 = 2'b10;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_INC  = 2'd1,
    PH_ILL  = 2'd2,
    PH_DEC  = 2'd3
  } ph_delta_e;

  function automatic logic [1:0] quad_idx(input logic [1:0] ba);
    case (ba)
      QUAD_S0: quad_idx = 2'd0;
      QUAD_S1: quad_idx = 2'd1;
      QUAD_S2: quad_idx = 2'd2;
      QUAD_S3: quad_idx = 2'd3;
      default: quad_idx = 2'd0;
    endcase
  endfunction

  // Distance around the Gray ring: 1 = CW, 3 = CCW, 2 = both bits flipped.
  function automatic ph_delta_e phase_delta(input logic [1:0] from_ba,
                                            input logic [1:0] to_ba);
    logic [1:0] diff;
    diff = quad_idx(to_ba) - quad_idx(from_ba);
    phase_delta = ph_delta_e'(diff);
  endfunction

endpackage

// File: rtl/rot_enc_ch.sv
// One encoder channel: pin sync, debounce, quadrature decode, detent divider,
// signed position and a single pending direction-event slot.
module rot_enc_ch
  import rot_enc_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEB_LEN  = 8,
  parameter int STEP_DIV = 4,
  parameter int WRAP     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rot_a,
  input  logic                    rot_b,
  input  logic                    pos_clr,
  input  logic                    pend_ack,
  output logic signed [CNT_W-1:0] pos,
  output logic                    pend_valid,
  output logic                    pend_dir,
  output logic                    err,
  output logic                    lost
);

  localparam int DEB_W = $clog2(DEB_LEN + 1);
  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [3:0] DIV_P = 4'(STEP_DIV);
  localparam logic signed [3:0] DIV_N = -DIV_P;

  logic [1:0]        sync1, sync2, cand, comm;
  logic [DEB_W-1:0]  deb_cnt;
  logic              first;
  logic signed [2:0] phase;
  logic signed [3:0] phase_nxt;
  logic              commit, step_up, step_dn;
  ph_delta_e         delta;

  // First commit after reset/clear fires even when cand matches comm.
  assign commit = (sync2 == cand) && (deb_cnt == DEB_W'(DEB_LEN)) &&
                  (first || (cand != comm));
  assign delta  = phase_delta(comm, cand);

  always_comb begin
    phase_nxt = {phase[2], phase};
    if (commit && !first) begin
      if (delta == PH_INC)      phase_nxt = phase_nxt + 4'sd1;
      else if (delta == PH_DEC) phase_nxt = phase_nxt - 4'sd1;
    end
  end

  assign step_up = !pos_clr && (phase_nxt >= DIV_P);
  assign step_dn = !pos_clr && (phase_nxt <= DIV_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      comm       <= '0;
      deb_cnt    <= '0;
      first      <= 1'b1;
      phase      <= '0;
      pos        <= '0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_RIGHT;
      err        <= 1'b0;
      lost       <= 1'b0;
    end else begin
      sync1 <= {rot_b, rot_a};
      sync2 <= sync1;
      err   <= 1'b0;
      lost  <= 1'b0;

      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= DEB_W'(1);
      end else if (deb_cnt != DEB_W'(DEB_LEN)) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end

      if (commit) begin
        comm  <= cand;
        first <= 1'b0;
      end

      if (pend_ack) pend_valid <= 1'b0;

      if (pos_clr) begin
        pos   <= '0;
        phase <= '0;
        first <= 1'b1;
      end else if (commit && !first) begin
        if (delta == PH_ILL) err <= 1'b1;
        if (step_up || step_dn) begin
          phase <= '0;
          if (step_up) begin
            if (WRAP != 0 || pos != POS_MAX) pos <= pos + CNT_W'(1);
          end else begin
            if (WRAP != 0 || pos != POS_MIN) pos <= pos - CNT_W'(1);
          end
          // An accept on this edge frees the slot for the new step.
          if (pend_valid && !pend_ack) begin
            lost <= 1'b1;
          end else begin
            pend_valid <= 1'b1;
            pend_dir   <= step_up ? DIR_RIGHT : DIR_LEFT;
          end
        end else begin
          phase <= phase_nxt[2:0];
        end
      end
    end
  end

endmodule

// File: rtl/rot_enc_multi.sv
// Multi-channel rotary-encoder front end: per-channel decoders plus a
// round-robin arbiter feeding a single registered valid/ready event port.
module rot_enc_multi
  import rot_enc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int DEB_LEN  = 8,
  parameter int STEP_DIV = 4,
  parameter int WRAP     = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       rot_a,
  input  logic [NUM_CH-1:0]       rot_b,
  input  logic [NUM_CH-1:0]       pos_clr,
  output logic [NUM_CH*CNT_W-1:0] pos_o,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [CH_W-1:0]         evt_ch,
  output logic                    evt_dir,
  output logic [NUM_CH-1:0]       err_o,
  output logic [NUM_CH-1:0]       lost_o
);

  logic [NUM_CH-1:0] pend_valid, pend_dir, pend_ack;
  logic [CH_W-1:0]   last_ch, pick_ch;
  logic              pick_found;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign pend_ack[i] = evt_valid && evt_ready && (evt_ch == CH_W'(i));

    rot_enc_ch #(
      .CNT_W   (CNT_W),
      .DEB_LEN (DEB_LEN),
      .STEP_DIV(STEP_DIV),
      .WRAP    (WRAP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .rot_a     (rot_a[i]),
      .rot_b     (rot_b[i]),
      .pos_clr   (pos_clr[i]),
      .pend_ack  (pend_ack[i]),
      .pos       (pos_o[i*CNT_W +: CNT_W]),
      .pend_valid(pend_valid[i]),
      .pend_dir  (pend_dir[i]),
      .err       (err_o[i]),
      .lost      (lost_o[i])
    );
  end

  // Search starts one past the last granted channel.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_ch) + k) % NUM_CH;
      if (!pick_found && pend_valid[idx]) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
  end

  // Slots stay occupied until the consumer accepts, so the presented event
  // is a stable copy; the idle cycle after acceptance lets the slot clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_dir   <= DIR_RIGHT;
      last_ch   <= CH_W'(NUM_CH - 1);
    end else if (evt_valid) begin
      if (evt_ready) evt_valid <= 1'b0;
    end else if (pick_found) begin
      evt_valid <= 1'b1;
      evt_ch    <= pick_ch;
      evt_dir   <= pend_dir[pick_ch];
      last_ch   <= pick_ch;
    end
  end

endmodule

// File: tb/tb_rot_enc_multi.sv
// Scoreboard bench for rot_enc_multi: saturating and wrapping instances share
// stimulus; expected events are queued as detents are driven.
module tb_rot_enc_multi;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 4;
  localparam int DEB_LEN  = 4;
  localparam int STEP_DIV = 4;
  localparam int HOLD     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] rot_a = '0, rot_b = '0, pos_clr = '0;
  logic evt_ready = 1'b1;

  logic [NUM_CH*CNT_W-1:0] pos_o, pos_w;
  logic evt_valid, evt_valid_w, evt_dir, evt_dir_w;
  logic [0:0] evt_ch, evt_ch_w;
  logic [NUM_CH-1:0] err_o, err_w, lost_o, lost_w;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_ev;
  int exp_pos[NUM_CH], exp_wrap[NUM_CH];
  int err_cnt[NUM_CH], err_cnt_w[NUM_CH], lost_cnt[NUM_CH], lost_cnt_w[NUM_CH];
  int evt_seen = 0;
  bit prev_acc = 0;

  always #5 clk = ~clk;

  rot_enc_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEB_LEN(DEB_LEN),
                  .STEP_DIV(STEP_DIV), .WRAP(0)) dut (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .pos_clr(pos_clr),
    .pos_o(pos_o), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_dir(evt_dir), .err_o(err_o), .lost_o(lost_o));

  rot_enc_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEB_LEN(DEB_LEN),
                  .STEP_DIV(STEP_DIV), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .pos_clr(pos_clr),
    .pos_o(pos_w), .evt_valid(evt_valid_w), .evt_ready(evt_ready),
    .evt_ch(evt_ch_w), .evt_dir(evt_dir_w), .err_o(err_w), .lost_o(lost_w));

  // Event scoreboard and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (err_o[i])  err_cnt[i]++;
        if (err_w[i])  err_cnt_w[i]++;
        if (lost_o[i]) lost_cnt[i]++;
        if (lost_w[i]) lost_cnt_w[i]++;
      end
      if (prev_acc) begin
        checks++;
        if (evt_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap: evt_valid=%b after accept, want 0", evt_valid);
        end
      end
      prev_acc = evt_valid && evt_ready;
      if (evt_valid && evt_ready) begin
        checks++;
        evt_seen++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_evt: ch=%0d dir=%0d, none expected", evt_ch, evt_dir);
        end else begin
          exp_ev = exp_q.pop_front();
          if ({evt_ch, evt_dir} !== exp_ev) begin
            errors++;
            $display("FAIL evt_order: got ch=%0d dir=%0d want ch=%0d dir=%0d",
                     evt_ch, evt_dir, exp_ev[1], exp_ev[0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [1:0] next_cw(input logic [1:0] p);
    case (p)
      2'b00:   next_cw = 2'b01;
      2'b01:   next_cw = 2'b11;
      2'b11:   next_cw = 2'b10;
      default: next_cw = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] next_ccw(input logic [1:0] p);
    case (p)
      2'b00:   next_ccw = 2'b10;
      2'b10:   next_ccw = 2'b11;
      2'b11:   next_ccw = 2'b01;
      default: next_ccw = 2'b00;
    endcase
  endfunction

  function automatic int pos_of(input int ch, input bit wr);
    logic signed [CNT_W-1:0] v;
    v = wr ? pos_w[ch*CNT_W +: CNT_W] : pos_o[ch*CNT_W +: CNT_W];
    return int'(v);
  endfunction

  task automatic move(input logic [NUM_CH-1:0] mask, input logic dir);
    logic [1:0] p;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        p = {rot_b[c], rot_a[c]};
        p = dir ? next_ccw(p) : next_cw(p);
        rot_b[c] = p[1];
        rot_a[c] = p[0];
      end
    end
  endtask

  task automatic detent(input logic [NUM_CH-1:0] mask, input logic dir);
    for (int s = 0; s < 4; s++) begin
      move(mask, dir);
      ticks(HOLD);
    end
  endtask

  task automatic model_step(input int ch, input logic dir, input bit push);
    logic [1:0] ev;
    if (dir == 1'b0) begin
      if (exp_pos[ch] < 7) exp_pos[ch]++;
      exp_wrap[ch]++;
      if (exp_wrap[ch] > 7) exp_wrap[ch] -= 16;
    end else begin
      if (exp_pos[ch] > -8) exp_pos[ch]--;
      exp_wrap[ch]--;
      if (exp_wrap[ch] < -8) exp_wrap[ch] += 16;
    end
    ev = {ch[0], dir};
    if (push) exp_q.push_back(ev);
  endtask

  task automatic clear_ch(input logic [NUM_CH-1:0] mask);
    pos_clr = mask;
    tick();
    pos_clr = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (mask[c]) begin exp_pos[c] = 0; exp_wrap[c] = 0; end
    ticks(HOLD);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: %0d events still expected", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    checks++;
    if ({evt_valid, evt_ch, evt_dir, pos_o, err_o, lost_o} !== '0) begin
      errors++;
      $display("FAIL reset_sat: outputs=%h want 0", {evt_valid, evt_ch, evt_dir, pos_o, err_o, lost_o});
    end
    checks++;
    if ({evt_valid_w, evt_ch_w, evt_dir_w, pos_w, err_w, lost_w} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: outputs=%h want 0", {evt_valid_w, evt_ch_w, evt_dir_w, pos_w, err_w, lost_w});
    end
    rst = 1'b0;
    ticks(HOLD);
  endtask

  task automatic test_cw_latency();
    int prev;
    prev = exp_pos[0];
    model_step(0, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin move(2'b01, 1'b0); ticks(HOLD); end
    move(2'b01, 1'b0);
    ticks(DEB_LEN + 2);
    checks++;
    if (pos_of(0, 0) !== prev) begin
      errors++;
      $display("FAIL latency_early: pos=%0d want %0d", pos_of(0, 0), prev);
    end
    tick();
    checks++;
    if (pos_of(0, 0) !== exp_pos[0] || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge: pos=%0d valid=%b want %0d 0", pos_of(0, 0), evt_valid, exp_pos[0]);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL evt_rise: valid=%b want 1", evt_valid);
    end
    ticks(HOLD);
    wait_drain();
  endtask

  task automatic test_ccw_glitch();
    int e0;
    for (int d = 0; d < 3; d++) begin
      model_step(0, 1'b1, 1'b1);
      detent(2'b01, 1'b1);
    end
    checks++;
    if (pos_of(0, 0) !== exp_pos[0]) begin
      errors++;
      $display("FAIL ccw_pos: pos=%0d want %0d", pos_of(0, 0), exp_pos[0]);
    end
    wait_drain();
    e0 = err_cnt[0];
    for (int g = 0; g < 2; g++) begin
      rot_a = ~rot_a;
      ticks(3);
      rot_a = ~rot_a;
      ticks(HOLD);
    end
    checks++;
    if (pos_of(0, 0) !== exp_pos[0] || pos_of(1, 0) !== exp_pos[1] ||
        err_cnt[0] !== e0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch: pos0=%0d pos1=%0d err=%0d want %0d %0d %0d",
               pos_of(0, 0), pos_of(1, 0), err_cnt[0], exp_pos[0], exp_pos[1], e0);
    end
  endtask

  task automatic test_saturate_wrap();
    int seen0;
    clear_ch(2'b11);
    seen0 = evt_seen;
    for (int d = 0; d < 9; d++) begin
      model_step(0, 1'b0, 1'b1);
      detent(2'b01, 1'b0);
    end
    wait_drain();
    checks++;
    if (pos_of(0, 0) !== 7) begin
      errors++;
      $display("FAIL saturate: pos=%0d want 7", pos_of(0, 0));
    end
    checks++;
    if (pos_of(0, 1) !== -7) begin
      errors++;
      $display("FAIL wrap: pos=%0d want -7", pos_of(0, 1));
    end
    checks++;
    if (evt_seen - seen0 !== 9) begin
      errors++;
      $display("FAIL sat_events: got %0d events want 9", evt_seen - seen0);
    end
  endtask

  task automatic test_illegal();
    int e0, ew0;
    clear_ch(2'b01);
    e0 = err_cnt[0];
    ew0 = err_cnt_w[0];
    rot_a[0] = 1'b1;
    rot_b[0] = 1'b1;
    ticks(HOLD);
    checks++;
    if (err_cnt[0] - e0 !== 1 || err_cnt_w[0] - ew0 !== 1 || pos_of(0, 0) !== 0) begin
      errors++;
      $display("FAIL illegal_err: err=%0d errw=%0d pos=%0d want 1 1 0",
               err_cnt[0] - e0, err_cnt_w[0] - ew0, pos_of(0, 0));
    end
    for (int s = 0; s < 3; s++) begin move(2'b01, 1'b0); ticks(HOLD); end
    checks++;
    if (pos_of(0, 0) !== 0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_phase: pos=%0d valid=%b want 0 0", pos_of(0, 0), evt_valid);
    end
    model_step(0, 1'b0, 1'b1);
    move(2'b01, 1'b0);
    ticks(HOLD);
    checks++;
    if (pos_of(0, 0) !== exp_pos[0]) begin
      errors++;
      $display("FAIL illegal_resume: pos=%0d want %0d", pos_of(0, 0), exp_pos[0]);
    end
    wait_drain();
  endtask

  task automatic test_lost_arb();
    int l0, l1, lw0;
    evt_ready = 1'b0;
    l0 = lost_cnt[0];
    l1 = lost_cnt[1];
    lw0 = lost_cnt_w[0];
    model_step(0, 1'b0, 1'b1);
    detent(2'b01, 1'b0);
    model_step(0, 1'b0, 1'b0);
    model_step(1, 1'b0, 1'b1);
    detent(2'b11, 1'b0);
    checks++;
    if (lost_cnt[0] - l0 !== 1 || lost_cnt[1] !== l1 || lost_cnt_w[0] - lw0 !== 1) begin
      errors++;
      $display("FAIL lost: lost0=%0d lost1=%0d lostw=%0d want 1 0 1",
               lost_cnt[0] - l0, lost_cnt[1] - l1, lost_cnt_w[0] - lw0);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 1'b0 || evt_dir !== 1'b0) begin
      errors++;
      $display("FAIL held_evt: valid=%b ch=%0d dir=%0d want 1 0 0", evt_valid, evt_ch, evt_dir);
    end
    checks++;
    if (pos_of(0, 0) !== exp_pos[0] || pos_of(1, 0) !== exp_pos[1]) begin
      errors++;
      $display("FAIL lost_pos: pos0=%0d pos1=%0d want %0d %0d",
               pos_of(0, 0), pos_of(1, 0), exp_pos[0], exp_pos[1]);
    end
    evt_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_clr_step();
    for (int s = 0; s < 3; s++) begin move(2'b10, 1'b0); ticks(HOLD); end
    move(2'b10, 1'b0);
    ticks(DEB_LEN + 2);
    pos_clr = 2'b10;
    tick();
    pos_clr = '0;
    exp_pos[1] = 0;
    exp_wrap[1] = 0;
    ticks(HOLD);
    checks++;
    if (pos_of(1, 0) !== 0 || pos_of(1, 1) !== 0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_step: pos=%0d posw=%0d valid=%b want 0 0 0",
               pos_of(1, 0), pos_of(1, 1), evt_valid);
    end
    model_step(1, 1'b0, 1'b1);
    detent(2'b10, 1'b0);
    checks++;
    if (pos_of(1, 0) !== exp_pos[1]) begin
      errors++;
      $display("FAIL clr_phase: pos=%0d want %0d", pos_of(1, 0), exp_pos[1]);
    end
    wait_drain();
  endtask

  task automatic test_rst_mid();
    evt_ready = 1'b0;
    model_step(1, 1'b0, 1'b1);
    detent(2'b10, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: valid=%b ch=%0d want 1 1", evt_valid, evt_ch);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({evt_valid, evt_ch, evt_dir, pos_o, err_o, lost_o} !== '0 ||
        {evt_valid_w, evt_ch_w, evt_dir_w, pos_w} !== '0) begin
      errors++;
      $display("FAIL rst_mid: outputs=%h want 0", {evt_valid, evt_ch, evt_dir, pos_o, err_o, lost_o});
    end
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin exp_pos[c] = 0; exp_wrap[c] = 0; end
    rst = 1'b0;
    evt_ready = 1'b1;
    ticks(2 * HOLD);
    checks++;
    if (evt_valid !== 1'b0 || pos_o !== '0) begin
      errors++;
      $display("FAIL rst_drop: valid=%b pos=%h want 0 0", evt_valid, pos_o);
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      exp_pos[c] = 0; exp_wrap[c] = 0;
      err_cnt[c] = 0; err_cnt_w[c] = 0; lost_cnt[c] = 0; lost_cnt_w[c] = 0;
    end
    test_reset();
    test_cw_latency();
    test_ccw_glitch();
    test_saturate_wrap();
    test_illegal();
    test_lost_arb();
    test_clr_step();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
